// File: rtl/fifo_rd_packer_if.sv
// Signal bundle between fifo_rd_packer and its FIFO read port, flush control and output stream.
// Member names are seen from the packer: _i are driven into it, _o are driven by it.
interface fifo_rd_packer_if #(
  parameter int unsigned DATA_WTH = 8,
  parameter int unsigned PACK_NUM = 4
) ();

  logic [DATA_WTH-1:0]          fifo_rd_data_i;
  logic                         fifo_empty_i;
  logic                         fifo_rd_en_o;
  logic                         flush_i;
  logic                         flush_done_o;
  logic [DATA_WTH*PACK_NUM-1:0] out_data_o;
  logic [PACK_NUM-1:0]          out_keep_o;
  logic                         out_last_o;
  logic                         out_valid_o;
  logic                         out_ready_i;
  logic                         busy_o;

  modport master (
    input  fifo_rd_data_i, fifo_empty_i, flush_i, out_ready_i,
    output fifo_rd_en_o, flush_done_o, out_data_o, out_keep_o, out_last_o, out_valid_o, busy_o
  );

  modport slave (
    output fifo_rd_data_i, fifo_empty_i, flush_i, out_ready_i,
    input  fifo_rd_en_o, flush_done_o, out_data_o, out_keep_o, out_last_o, out_valid_o, busy_o
  );

endinterface

// File: rtl/fifo_rd_packer.sv
// Drains a first-word-fall-through FIFO and packs PACK_NUM words into one wide valid/ready beat;
// a flush closes out a trailing partial beat with a lane mask.
module fifo_rd_packer #(
  parameter int unsigned DATA_WTH = 8,
  parameter int unsigned PACK_NUM = 4,
  parameter int unsigned IDX_WTH  = 2
) (
  input logic              clk_i,
  input logic              rst_i,
  fifo_rd_packer_if.master bus
);

  localparam int unsigned BeatWth = DATA_WTH * PACK_NUM;

  typedef enum logic [0:0] {StFill, StSend} state_e;

  state_e              state_q, state_d;
  logic [IDX_WTH-1:0]  idx_q, idx_d;
  logic [BeatWth-1:0]  data_q, data_d;
  logic [PACK_NUM-1:0] keep_q, keep_d;
  logic                last_q, last_d;
  logic                flush_pend_q, flush_pend_d;
  logic                flush_done_q, flush_done_d;
  logic                rd_en;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    data_d       = data_q;
    keep_d       = keep_q;
    last_d       = last_q;
    flush_pend_d = flush_pend_q | bus.flush_i;
    flush_done_d = 1'b0;
    rd_en        = 1'b0;

    unique case (state_q)
      StFill: begin
        rd_en = ~bus.fifo_empty_i;
        if (rd_en) begin
          for (int unsigned k = 0; k < PACK_NUM; k++) begin
            if (idx_q == IDX_WTH'(k)) begin
              data_d[k*DATA_WTH +: DATA_WTH] = bus.fifo_rd_data_i;
              keep_d[k]                      = 1'b1;
            end
          end
          if (idx_q == IDX_WTH'(PACK_NUM - 1)) begin
            idx_d   = '0;
            last_d  = 1'b0;
            state_d = StSend;
          end else begin
            idx_d = idx_q + IDX_WTH'(1);
          end
        end else if (flush_pend_q) begin
          // FIFO fully drained: close the partial beat, or finish at once if nothing is held.
          // A flush_i arriving now is absorbed by this completion.
          if (idx_q != '0) begin
            last_d  = 1'b1;
            state_d = StSend;
          end else begin
            flush_pend_d = 1'b0;
            flush_done_d = 1'b1;
          end
        end
      end

      StSend: begin
        if (bus.out_ready_i) begin
          data_d  = '0;
          keep_d  = '0;
          idx_d   = '0;
          last_d  = 1'b0;
          state_d = StFill;
          if (last_q) begin
            flush_pend_d = 1'b0;
            flush_done_d = 1'b1;
          end
        end
      end

      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StFill;
      idx_q        <= '0;
      data_q       <= '0;
      keep_q       <= '0;
      last_q       <= 1'b0;
      flush_pend_q <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      keep_q       <= keep_d;
      last_q       <= last_d;
      flush_pend_q <= flush_pend_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign bus.fifo_rd_en_o = rd_en;
  assign bus.out_data_o   = data_q;
  assign bus.out_keep_o   = keep_q;
  assign bus.out_last_o   = last_q;
  assign bus.out_valid_o  = (state_q == StSend);
  assign bus.flush_done_o = flush_done_q;
  assign bus.busy_o       = (state_q == StSend) | (idx_q != '0) | flush_pend_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer: a queue models the FWFT FIFO, expected beats are queued
// as stimulus is driven and checked as the packer hands them over.
module tb_fifo_rd_packer;

  localparam int unsigned DW = 8;
  localparam int unsigned PN = 4;
  localparam int unsigned IW = 2;

  typedef struct packed {
    logic [DW*PN-1:0] data;
    logic [PN-1:0]    keep;
    logic             last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  fifo_rd_packer_if #(.DATA_WTH(DW), .PACK_NUM(PN)) bus ();

  fifo_rd_packer #(
    .DATA_WTH(DW),
    .PACK_NUM(PN),
    .IDX_WTH (IW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_pops  = 0;
  int          n_done  = 0;
  int          pops0;
  int          done0;
  logic [DW-1:0] fifo_q[$];
  beat_t       exp_q[$];
  beat_t       mon_e;
  logic        chk_done_nxt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    bus.fifo_empty_i   = (fifo_q.size() == 0);
    bus.fifo_rd_data_i = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    refresh();
  endtask

  task automatic expect_beat(input logic [DW*PN-1:0] d, input logic [PN-1:0] k, input logic l);
    beat_t b;
    b.data = d;
    b.keep = k;
    b.last = l;
    exp_q.push_back(b);
  endtask

  // One clock: the pop decision is taken while inputs are stable, the FIFO model updates after.
  task automatic step(input int n);
    logic pop_now;
    repeat (n) begin
      @(negedge clk);
      pop_now = bus.fifo_rd_en_o & ~rst;
      @(posedge clk);
      #2;
      if (pop_now) begin
        chk("pop_not_empty", 64'(fifo_q.size() != 0), 64'd1);
        if (fifo_q.size() != 0) void'(fifo_q.pop_front());
        n_pops++;
        refresh();
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    int cnt;
    cnt = 0;
    while ((exp_q.size() != 0 || bus.busy_o !== 1'b0 || fifo_q.size() != 0) && cnt < 60) begin
      step(1);
      cnt++;
    end
    chk(tag, 64'(exp_q.size() == 0 && bus.busy_o === 1'b0), 64'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 64'(bus.out_valid_o), 64'd0);
    chk({tag, "_keep"},  64'(bus.out_keep_o),  64'd0);
    chk({tag, "_data"},  64'(bus.out_data_o),  64'd0);
    chk({tag, "_last"},  64'(bus.out_last_o),  64'd0);
    chk({tag, "_done"},  64'(bus.flush_done_o), 64'd0);
    chk({tag, "_busy"},  64'(bus.busy_o),      64'd0);
    chk({tag, "_rd_en"}, 64'(bus.fifo_rd_en_o), 64'd0);
  endtask

  // Scoreboard side: compare every accepted beat and the flush_done pulse that must follow a
  // last beat.
  always @(negedge clk) begin
    if (rst) begin
      chk_done_nxt = 1'b0;
    end else begin
      if (chk_done_nxt) chk("done_after_last", 64'(bus.flush_done_o), 64'd1);
      chk_done_nxt = 1'b0;
      if (bus.flush_done_o === 1'b1) n_done++;
      if (bus.out_valid_o === 1'b1 && bus.out_ready_i === 1'b1) begin
        chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("beat_data", 64'(bus.out_data_o), 64'(mon_e.data));
          chk("beat_keep", 64'(bus.out_keep_o), 64'(mon_e.keep));
          chk("beat_last", 64'(bus.out_last_o), 64'(mon_e.last));
        end
        chk_done_nxt = bus.out_last_o;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, required finish before 100000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst             = 1'b1;
    bus.flush_i     = 1'b0;
    bus.out_ready_i = 1'b0;
    refresh();
    step(2);
    chk_reset_outputs("reset");
    rst = 1'b0;
    step(1);

    // Single full beat, ready held high.
    bus.out_ready_i = 1'b1;
    pops0 = n_pops;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    expect_beat(32'h4433_2211, 4'b1111, 1'b0);
    step(3);
    chk("t1_valid_early", 64'(bus.out_valid_o), 64'd0);
    step(1);
    chk("t1_valid", 64'(bus.out_valid_o), 64'd1);
    chk("t1_pops_at_valid", 64'(n_pops - pops0), 64'd4);
    step(2);
    chk("t1_pops_total", 64'(n_pops - pops0), 64'd4);
    chk("t1_valid_after", 64'(bus.out_valid_o), 64'd0);

    // Backpressure with a second beat's worth of words waiting.
    bus.out_ready_i = 1'b0;
    pops0 = n_pops;
    for (int i = 1; i <= 8; i++) push(8'(i));
    expect_beat(32'h0403_0201, 4'b1111, 1'b0);
    expect_beat(32'h0807_0605, 4'b1111, 1'b0);
    step(4);
    chk("t2_valid", 64'(bus.out_valid_o), 64'd1);
    for (int c = 0; c < 5; c++) begin
      step(1);
      chk("t2_hold_rd_en", 64'(bus.fifo_rd_en_o), 64'd0);
      chk("t2_hold_data", 64'(bus.out_data_o), 64'h0403_0201);
      chk("t2_hold_valid", 64'(bus.out_valid_o), 64'd1);
    end
    bus.out_ready_i = 1'b1;
    wait_idle("t2_idle");
    chk("t2_pops", 64'(n_pops - pops0), 64'd8);

    // Partial beat closed by flush.
    done0 = n_done;
    push(8'hA1); push(8'hB2); push(8'hC3);
    expect_beat(32'h00C3_B2A1, 4'b0111, 1'b1);
    step(3);
    bus.flush_i = 1'b1;
    step(1);
    bus.flush_i = 1'b0;
    wait_idle("t3_idle");
    step(2);
    chk("t3_done_count", 64'(n_done - done0), 64'd1);
    chk("t3_busy", 64'(bus.busy_o), 64'd0);

    // Flush with nothing buffered: no beat, just the done pulse.
    done0 = n_done;
    bus.flush_i = 1'b1;
    step(1);
    bus.flush_i = 1'b0;
    step(1);
    chk("t4_done_pulse", 64'(bus.flush_done_o), 64'd1);
    step(2);
    chk("t4_done_count", 64'(n_done - done0), 64'd1);
    chk("t4_no_beat", 64'(bus.out_valid_o), 64'd0);

    // Flush raised while a full beat is stalled; the remainder becomes the last beat.
    bus.out_ready_i = 1'b0;
    done0 = n_done;
    for (int i = 0; i < 6; i++) push(8'(8'h10 + i));
    expect_beat(32'h1312_1110, 4'b1111, 1'b0);
    expect_beat(32'h0000_1514, 4'b0011, 1'b1);
    step(4);
    chk("t5_valid", 64'(bus.out_valid_o), 64'd1);
    bus.flush_i = 1'b1;
    step(1);
    bus.flush_i = 1'b0;
    step(2);
    chk("t5_hold_rd_en", 64'(bus.fifo_rd_en_o), 64'd0);
    chk("t5_first_last", 64'(bus.out_last_o), 64'd0);
    bus.out_ready_i = 1'b1;
    wait_idle("t5_idle");
    step(2);
    chk("t5_done_count", 64'(n_done - done0), 64'd1);

    // Reset in the middle of a stalled beat with a pending flush and words still queued.
    bus.out_ready_i = 1'b0;
    done0 = n_done;
    for (int i = 0; i < 6; i++) push(8'(8'h20 + i));
    step(4);
    chk("t6_valid", 64'(bus.out_valid_o), 64'd1);
    bus.flush_i = 1'b1;
    step(1);
    bus.flush_i = 1'b0;
    rst = 1'b1;
    fifo_q.delete();
    refresh();
    step(1);
    chk_reset_outputs("t6_reset");
    rst = 1'b0;
    bus.out_ready_i = 1'b1;
    push(8'h31); push(8'h32); push(8'h33); push(8'h34);
    expect_beat(32'h3433_3231, 4'b1111, 1'b0);
    wait_idle("t6_idle");
    step(2);
    chk("t6_no_done", 64'(n_done - done0), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
